// File: rtl/decode_pkg.sv
// Shared decode constants, type-bit indices and the decoded bundle layout.
// Immediates are carried outside decoded_t because their width is a module parameter.
package decode_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 21;

  localparam int TYPE_MATH    = 0;
  localparam int TYPE_BRANCH  = 1;
  localparam int TYPE_SETFLAG = 2;
  localparam int TYPE_HALT    = 3;
  localparam int TYPE_ILLEGAL = 4;

  localparam logic [10:0] HALT_OPCODE = 11'h7FF;
  localparam logic [2:0]  BRANCH_PAT  = 3'b100;
  localparam logic [4:0]  SETFLAG_PAT = 5'b10100;

  typedef struct packed {
    logic [10:0] opcode;
    logic [4:0]  typ;
    logic [4:0]  reg_in;
    logic [4:0]  reg_a;
    logic [4:0]  reg_b;
    logic [1:0]  regin_src;
    logic [1:0]  alub_src;
    logic        mem_rw;
    logic [3:0]  alu_op;
  } decoded_t;

  function automatic logic [10:0] opcode_of(input logic [31:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decoder: ir -> decoded_t plus extended immediates.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the caller decides when the result is captured.
module decode_logic
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINK_REG   = 31
) (
  input  logic [31:0]           ir,
  output decoded_t              dec,
  output logic [DATA_WIDTH-1:0] imm1_ze,
  output logic [DATA_WIDTH-1:0] imm1_se,
  output logic [DATA_WIDTH-1:0] imm2_ze,
  output logic [DATA_WIDTH-1:0] imm2_se,
  output logic [DATA_WIDTH-1:0] imm3_se
);

  logic [10:0] op;
  logic        is_branch;
  logic        is_setflag;
  logic        is_halt;
  logic [10:0] imm3_raw;

  assign op         = opcode_of(ir);
  assign is_branch  = (op[10:8] == BRANCH_PAT);
  assign is_setflag = (op[10:6] == SETFLAG_PAT);
  assign is_halt    = (op == HALT_OPCODE);
  assign imm3_raw   = {ir[20:16], ir[5:0]};

  always_comb begin
    dec                    = '0;
    dec.opcode             = op;
    dec.typ[TYPE_MATH]     = !op[10];
    dec.typ[TYPE_BRANCH]   = is_branch;
    dec.typ[TYPE_SETFLAG]  = is_setflag;
    dec.typ[TYPE_HALT]     = is_halt;
    dec.typ[TYPE_ILLEGAL]  = op[10] && !(is_branch || is_setflag || is_halt);
    // Link branches (op[7]) always write the link register.
    dec.reg_in             = (is_branch && op[7]) ? 5'(LINK_REG) : ir[20:16];
    dec.reg_a              = ir[15:11];
    dec.reg_b              = ir[10:6];
    dec.regin_src          = op[9:8];
    dec.alub_src           = op[7:6];
    dec.mem_rw             = op[5];
    dec.alu_op             = op[3:0];
  end

  assign imm1_ze = {{(DATA_WIDTH-16){1'b0}}, ir[15:0]};
  assign imm1_se = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};
  assign imm2_ze = {{(DATA_WIDTH-11){1'b0}}, ir[10:0]};
  assign imm2_se = {{(DATA_WIDTH-11){ir[10]}}, ir[10:0]};
  assign imm3_se = {{(DATA_WIDTH-11){imm3_raw[10]}}, imm3_raw};

endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: fetch words queue in a DEPTH-entry FIFO and decode into a registered bundle.
// Latency: 1 cycle when the stage is empty (bypass), otherwise in program order behind queued words.
// Backpressure: in_ready depends only on registered state (halt, FIFO count) and flush, never on out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 2,
  parameter int LINK_REG   = 31
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_ir,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [10:0]                  out_opcode,
  output logic [4:0]                   out_type,
  output logic [4:0]                   out_reg_in,
  output logic [4:0]                   out_reg_a,
  output logic [4:0]                   out_reg_b,
  output logic [DATA_WIDTH-1:0]        out_imm1_ze,
  output logic [DATA_WIDTH-1:0]        out_imm1_se,
  output logic [DATA_WIDTH-1:0]        out_imm2_ze,
  output logic [DATA_WIDTH-1:0]        out_imm2_se,
  output logic [DATA_WIDTH-1:0]        out_imm3_se,
  output logic [1:0]                   out_regin_src,
  output logic [1:0]                   out_alub_src,
  output logic                         out_mem_rw,
  output logic [3:0]                   out_alu_op,
  output logic                         halted,
  output logic [$clog2(DEPTH+2)-1:0]   level
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 2);

  logic [31:0]         fifo_ir [DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic load_en;
  logic pop;
  logic bypass;
  logic push;
  logic load;

  logic [31:0]           src_ir;
  logic [PC_WIDTH-1:0]   src_pc;
  decoded_t              src_dec;
  logic [DATA_WIDTH-1:0] src_imm1_ze, src_imm1_se, src_imm2_ze, src_imm2_se, src_imm3_se;

  decoded_t              dec_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0] imm1_ze_q, imm1_se_q, imm2_ze_q, imm2_se_q, imm3_se_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign in_ready   = !halted && !flush && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign load_en    = !out_valid || out_ready;
  // The queue head always wins over the incoming word so program order holds.
  assign pop        = load_en && !fifo_empty;
  assign bypass     = accept && fifo_empty && load_en;
  assign push       = accept && !bypass;
  assign load       = (pop || bypass) && !flush;

  assign src_ir = fifo_empty ? in_ir : fifo_ir[rd_ptr];
  assign src_pc = fifo_empty ? in_pc : fifo_pc[rd_ptr];

  decode_logic #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINK_REG   (LINK_REG)
  ) u_decode_logic (
    .ir      (src_ir),
    .dec     (src_dec),
    .imm1_ze (src_imm1_ze),
    .imm1_se (src_imm1_se),
    .imm2_ze (src_imm2_ze),
    .imm2_se (src_imm2_se),
    .imm3_se (src_imm3_se)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir[wr_ptr] <= in_ir;
      fifo_pc[wr_ptr] <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (accept && (opcode_of(in_ir) == HALT_OPCODE)) halted <= 1'b1;
      if (load_en) out_valid <= pop || bypass;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q     <= '0;
      pc_q      <= '0;
      imm1_ze_q <= '0;
      imm1_se_q <= '0;
      imm2_ze_q <= '0;
      imm2_se_q <= '0;
      imm3_se_q <= '0;
    end else if (load) begin
      dec_q     <= src_dec;
      pc_q      <= src_pc;
      imm1_ze_q <= src_imm1_ze;
      imm1_se_q <= src_imm1_se;
      imm2_ze_q <= src_imm2_ze;
      imm2_se_q <= src_imm2_se;
      imm3_se_q <= src_imm3_se;
    end
  end

  assign level         = LW'(count) + LW'(out_valid);
  assign out_pc        = pc_q;
  assign out_opcode    = dec_q.opcode;
  assign out_type      = dec_q.typ;
  assign out_reg_in    = dec_q.reg_in;
  assign out_reg_a     = dec_q.reg_a;
  assign out_reg_b     = dec_q.reg_b;
  assign out_regin_src = dec_q.regin_src;
  assign out_alub_src  = dec_q.alub_src;
  assign out_mem_rw    = dec_q.mem_rw;
  assign out_alu_op    = dec_q.alu_op;
  assign out_imm1_ze   = imm1_ze_q;
  assign out_imm1_se   = imm1_se_q;
  assign out_imm2_ze   = imm2_ze_q;
  assign out_imm2_se   = imm2_se_q;
  assign out_imm3_se   = imm3_se_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_decode_stage;

  localparam int DW    = 32;
  localparam int PW    = 32;
  localparam int DEPTH = 2;
  localparam int LINK  = 31;
  localparam int LW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_ir;
  logic [PW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pc;
  logic [10:0]   out_opcode;
  logic [4:0]    out_type;
  logic [4:0]    out_reg_in, out_reg_a, out_reg_b;
  logic [DW-1:0] out_imm1_ze, out_imm1_se, out_imm2_ze, out_imm2_se, out_imm3_se;
  logic [1:0]    out_regin_src, out_alub_src;
  logic          out_mem_rw;
  logic [3:0]    out_alu_op;
  logic          halted;
  logic [LW-1:0] level;

  decode_stage #(
    .DATA_WIDTH (DW),
    .PC_WIDTH   (PW),
    .DEPTH      (DEPTH),
    .LINK_REG   (LINK)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ir         (in_ir),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_opcode    (out_opcode),
    .out_type      (out_type),
    .out_reg_in    (out_reg_in),
    .out_reg_a     (out_reg_a),
    .out_reg_b     (out_reg_b),
    .out_imm1_ze   (out_imm1_ze),
    .out_imm1_se   (out_imm1_se),
    .out_imm2_ze   (out_imm2_ze),
    .out_imm2_se   (out_imm2_se),
    .out_imm3_se   (out_imm3_se),
    .out_regin_src (out_regin_src),
    .out_alub_src  (out_alub_src),
    .out_mem_rw    (out_mem_rw),
    .out_alu_op    (out_alu_op),
    .halted        (halted),
    .level         (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   ir;
    logic [PW-1:0] pc;
  } word_t;

  typedef struct {
    logic [10:0]   opcode;
    logic [4:0]    typ;
    logic [4:0]    rin, ra, rb;
    logic [DW-1:0] i1z, i1s, i2z, i2s, i3s;
    logic [1:0]    rs, bs;
    logic          mrw;
    logic [3:0]    aop;
  } exp_t;

  word_t q[$];
  bit    halted_m;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sext(input longint unsigned v, input int bits);
    longint s = longint'(v);
    if (((v >> (bits - 1)) & 1) != 0) s = s - (longint'(1) << bits);
    return DW'(s);
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] ir);
    exp_t        e;
    int unsigned w  = ir;
    int unsigned op = w >> 21;
    int unsigned i3;
    bit m, b, s, h, il;
    m  = (op < 1024);
    b  = ((op >> 8) == 4);
    s  = ((op >> 6) == 20);
    h  = (op == 2047);
    il = !m && !b && !s && !h;
    e.opcode = 11'(op);
    e.typ    = 5'(il * 16 + h * 8 + s * 4 + b * 2 + m);
    e.rin    = (b && ((op >> 7) % 2 == 1)) ? 5'(LINK) : 5'((w >> 16) % 32);
    e.ra     = 5'((w >> 11) % 32);
    e.rb     = 5'((w >> 6) % 32);
    e.i1z    = DW'(w % 65536);
    e.i1s    = sext(longint'(w % 65536), 16);
    e.i2z    = DW'(w % 2048);
    e.i2s    = sext(longint'(w % 2048), 11);
    i3       = ((w >> 16) % 32) * 64 + (w % 64);
    e.i3s    = sext(longint'(i3), 11);
    e.rs     = 2'((op >> 8) % 4);
    e.bs     = 2'((op >> 6) % 4);
    e.mrw    = 1'((op >> 5) % 2);
    e.aop    = 4'(op % 16);
    return e;
  endfunction

  task automatic check_all();
    int   tot = q.size();
    bit   rdy = !halted_m && !flush && (tot <= DEPTH);
    exp_t e;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(tot > 0));
    chk("level", 64'(level), 64'(tot));
    chk("halted", 64'(halted), 64'(halted_m));
    if (tot > 0) begin
      e = ref_dec(q[0].ir);
      chk("pc", 64'(out_pc), 64'(q[0].pc));
      chk("opcode", 64'(out_opcode), 64'(e.opcode));
      chk("type", 64'(out_type), 64'(e.typ));
      chk("reg_in", 64'(out_reg_in), 64'(e.rin));
      chk("reg_a", 64'(out_reg_a), 64'(e.ra));
      chk("reg_b", 64'(out_reg_b), 64'(e.rb));
      chk("imm1_ze", 64'(out_imm1_ze), 64'(e.i1z));
      chk("imm1_se", 64'(out_imm1_se), 64'(e.i1s));
      chk("imm2_ze", 64'(out_imm2_ze), 64'(e.i2z));
      chk("imm2_se", 64'(out_imm2_se), 64'(e.i2s));
      chk("imm3_se", 64'(out_imm3_se), 64'(e.i3s));
      chk("ctrl", 64'({out_regin_src, out_alub_src, out_mem_rw, out_alu_op}),
          64'({e.rs, e.bs, e.mrw, e.aop}));
    end
  endtask

  // One clock: drive at negedge, check the state left by the previous edge, then advance the model.
  task automatic cycle(input bit v, input logic [31:0] ir, input logic [PW-1:0] pc,
                       input bit ordy, input bit fl);
    bit    rdy;
    word_t wd;
    @(negedge clk);
    in_valid  = v;
    in_ir     = ir;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    rdy = !halted_m && !fl && (q.size() <= DEPTH);
    if (fl) begin
      q.delete();
      halted_m = 0;
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && rdy) begin
        wd.ir = ir;
        wd.pc = pc;
        q.push_back(wd);
        if ((ir >> 21) == 32'd2047) halted_m = 1;
      end
    end
  endtask

  function automatic logic [31:0] rnd_word();
    int unsigned k = $urandom_range(0, 99);
    logic [31:0] w = $urandom;
    if (k < 45)      w[31]    = 1'b0;
    else if (k < 65) w[31:29] = 3'b100;
    else if (k < 75) w[31:27] = 5'b10100;
    else if (k < 78) w[31:21] = 11'h7FF;
    return w;
  endfunction

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ir     = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    halted_m  = 0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_imm1_se", 64'(out_imm1_se), 64'd0);
    #10 reset_n = 1'b1;

    // Field decoding examples.
    cycle(1, 32'h00021900, 32'h100, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("tp_math_type", 64'(out_type), 64'b00001);
    chk("tp_math_regs", 64'({out_reg_in, out_reg_a, out_reg_b}), 64'({5'd2, 5'd3, 5'd4}));
    chk("tp_math_imm1_se", 64'(out_imm1_se), 64'h00001900);
    chk("tp_math_imm2_ze", 64'(out_imm2_ze), 64'h00000100);
    cycle(1, 32'h00008400, 32'h104, 1, 0);
    cycle(1, 32'h00100000, 32'h108, 1, 0);
    chk("tp_sx_imm1_ze", 64'(out_imm1_ze), 64'h00008400);
    chk("tp_sx_imm1_se", 64'(out_imm1_se), 64'hFFFF8400);
    chk("tp_sx_imm2_se", 64'(out_imm2_se), 64'hFFFFFC00);
    chk("tp_sx_imm3_se0", 64'(out_imm3_se), 64'h00000000);
    cycle(1, 32'h90030000, 32'h10C, 1, 0);
    chk("tp_sx_imm3_se1", 64'(out_imm3_se), 64'hFFFFFC00);
    cycle(1, 32'hC0000000, 32'h110, 1, 0);
    chk("tp_link_type", 64'(out_type), 64'b00010);
    chk("tp_link_reg", 64'(out_reg_in), 64'd31);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("tp_illegal_type", 64'(out_type), 64'b10000);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Backpressure: DEPTH+1 words held, head bundle stable.
    for (int i = 0; i < 4; i++) cycle(1, rnd_word() & 32'h7FFFFFFF, 32'h200 + 4 * i, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0);
    chk("bp_level", 64'(level), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_pc", 64'(out_pc), 64'h200);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Sticky halt and flush recovery.
    cycle(1, 32'h00021900, 32'h300, 1, 0);
    cycle(1, 32'hFFE00000, 32'h304, 1, 0);
    cycle(1, 32'h00021900, 32'h308, 1, 0);
    chk("halt_set", 64'(halted), 64'd1);
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 1);
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("flush_halted", 64'(halted), 64'd0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset with two words queued.
    for (int i = 0; i < 3; i++) cycle(1, 32'h00021900 + i, 32'h400 + 4 * i, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_level", 64'(level), 64'd0);
    q.delete();
    halted_m = 0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 9) < 7, rnd_word(), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, flow-controlled instruction decode stage for the next CPU generation.
- Accepts raw instruction words plus PC tag from fetch over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Decodes the head word into a registered output bundle that execute consumes over a second valid/ready handshake.
- Adds parametrised immediate width, buffering, illegal-opcode detection, sticky halt and flush beyond the single-cycle combinational decoder.

Parameters:
- DATA_WIDTH, 32: width of every extended immediate (>=21).
- PC_WIDTH, 32: width of the PC tag passed through.
- DEPTH, 2: input FIFO entries (>=1).
- LINK_REG, 31: destination register forced for link branches.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  stage can accept a word.
- in_ir  in  32  instruction word.
- in_pc  in  PC_WIDTH  PC of in_ir.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_WIDTH  PC tag.
- out_opcode  out  11  ir[31:21].
- out_type  out  5  {illegal, halt, set_flag_value, branch, math_flow}.
- out_reg_in, out_reg_a, out_reg_b  out  5 each  register fields.
- out_imm1_ze, out_imm1_se, out_imm2_ze, out_imm2_se, out_imm3_se  out  DATA_WIDTH each  immediates.
- out_regin_src  out  2, out_alub_src  out  2, out_mem_rw  out  1, out_alu_op  out  4  control fields.
- halted  out  1  sticky halt seen.
- level  out  $clog2(DEPTH+2)  words held (FIFO plus output register).

Behaviour:
- Decode (op = ir[31:21]):
  - regin_src = op[9:8]; alub_src = op[7:6]; mem_rw = op[5]; alu_op = op[3:0].
  - math_flow = !op[10]; branch = op[10:8]==100; set_flag_value = op[10:6]==10100; halt = op==11'h7FF.
  - illegal = op[10] && none of branch, set_flag_value, halt.
- Register fields:
  - reg_in = LINK_REG if branch && op[7], else ir[20:16].
  - reg_a = ir[15:11]; reg_b = ir[10:6].
- Immediates:
  - imm1 = ir[15:0]; imm2 = ir[10:0]; imm3 = {ir[20:16], ir[5:0]}, sign bit ir[20].
  - _ze forms zero-extend and _se forms sign-extend to DATA_WIDTH.
- Reset (async, reset_n=0): FIFO empty, out_valid=0, halted=0, level=0, all out_* data=0. Release is synchronous to clk.
- in_ready = !halted && !flush && (FIFO count < DEPTH). This is a registered-state function only, with no combinational path from out_ready.
- Acceptance = in_valid && in_ready at a rising edge.
- Bypass: if the FIFO is empty and (!out_valid || out_ready), the accepted word is decoded directly into the output register. Latency is 1 cycle: out_valid is high after the accepting edge. Otherwise the word is pushed into the FIFO.
- The output register reloads from the FIFO head on any edge where (!out_valid || out_ready) and the FIFO is non-empty. The FIFO has priority over the bypass, so program order is always preserved.
- Simultaneous push/pop on a full FIFO is not possible, because in_ready=0 when count==DEPTH. Push and pop on a partially full FIFO in the same cycle keep count unchanged.
- Output fields are held stable while out_valid && !out_ready.
- out_valid drops after a handshake when nothing is queued or bypassed.
- Halt:
  - Accepting a halt-type word sets halted at that edge, so no later word is accepted.
  - Words already queued, including the halt, still drain normally.
  - halted is cleared only by reset or flush.
- flush (highest priority):
  - Clears the FIFO, out_valid and halted at the edge.
  - in_valid is ignored in that cycle and any output handshake in that cycle is void.
  - out_* data may hold stale values.
- level counts the FIFO entries plus out_valid and is updated every edge.
- Pointer wrap: FIFO read/write indices wrap modulo DEPTH; count is used for full/empty, and DEPTH need not be a power of two.

Decomposition:
- Package decode_pkg:
  - Opcode field slice constants.
  - Type-bit index constants (TYPE_MATH=0 ... TYPE_ILLEGAL=4).
  - HALT_OPCODE=11'h7FF and the branch/set-flag match patterns.
  - A packed struct decoded_t holding every out_* field.
- Sub-module decode_logic:
  - Purely combinational, ir -> decoded_t, parametrised by DATA_WIDTH and LINK_REG.
  - Used on the bypass path and on the FIFO-head path (or a single instance on a muxed source).
- The FIFO stays inline.

Test Plan:
- Math word: in_ir=0x00021900 with out_ready=1 -> one cycle later out_valid=1, out_type=5'b00001, reg_in=2, reg_a=3, reg_b=4, imm1_se=0x00001900, imm2_ze=0x00000100.
- Sign extension: in_ir=0x00008400 -> imm1_ze=0x00008400, imm1_se=0xFFFF8400, imm2_se=0xFFFFFC00, imm3_se=0x00000000. Then in_ir=0x00100000 -> imm3_se=0xFFFFFC00.
- Link branch and illegal: in_ir=0x90030000 -> out_type=5'b00010, reg_in=31. Then in_ir=0xC0000000 -> out_type=5'b10000.
- Backpressure: out_ready=0 and stream 4 words -> DEPTH+1=3 accepted, in_ready=0, level=3, first bundle stable. Raise out_ready -> bundles emerge in order, one per cycle.
- Halt: stream math, 0xFFE00000, math -> halted=1 after the halt edge, third word never accepted, first two drain. Assert flush -> halted=0, level=0, in_ready=1 next cycle.
- Async reset mid-stream with FIFO holding 2 words -> out_valid=0 and level=0 immediately without a clock edge; no stale bundle appears after release.
